// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start bit, width data bits LSB first, optional parity bit, one stop bit.
// Each bit is majority-voted from three samples taken around the bit centre.
// Good frames load P_data and pulse Data_valid. Bad frames pulse Par_err and/or
// Stop_err instead, and P_data keeps its previous value.
module uart_rx #(
  parameter int width      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_in,
  input  logic             Par_en,
  input  logic             Par_type,
  output logic [width-1:0] P_data,
  output logic             Data_valid,
  output logic             Par_err,
  output logic             Stop_err,
  output logic             Busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (width > 1) ? $clog2(width) : 1;

  localparam logic [CW-1:0] EDGE_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SMP_EARLY = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP_MID   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP_LATE  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // 2-of-3 majority vote of the bit-centre samples
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Even parity (XOR reduction) of a data word
  function automatic logic parity_of(input logic [width-1:0] d);
    return ^d;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [width-1:0] shift_q, shift_d;
  logic [2:0]       smp_q, smp_d;
  logic             par_en_q, par_en_d;
  logic             par_type_q, par_type_d;
  logic             par_bad_q, par_bad_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic             data_valid_q, data_valid_d;
  logic             par_err_q, par_err_d;
  logic             stop_err_q, stop_err_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync2_q;

  logic             rx_s;
  logic             bit_end_s;
  logic             voted_s;
  logic [2:0]       vote_in_s;

  assign rx_s      = sync2_q;
  assign bit_end_s = (edge_cnt_q == EDGE_LAST);

  // The late sample may coincide with the end-of-bit cycle for small
  // oversampling ratios, so the vote uses the live line value in that case.
  assign vote_in_s = {((edge_cnt_q == SMP_LATE) ? rx_s : smp_q[2]), smp_q[1], smp_q[0]};
  assign voted_s   = majority3(vote_in_s);

  assign P_data     = p_data_q;
  assign Data_valid = data_valid_q;
  assign Par_err    = par_err_q;
  assign Stop_err   = stop_err_q;
  assign Busy       = busy_q;

  // Two-flop synchroniser on the serial line, idling high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: bit timing, sampling, frame FSM and output strobes
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    smp_d        = smp_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stop_err_d   = 1'b0;

    if (state_q != IDLE) begin
      if (bit_end_s) begin
        edge_cnt_d = {CW{1'b0}};
      end else begin
        edge_cnt_d = edge_cnt_q + CW'(1);
      end
      case (edge_cnt_q)
        SMP_EARLY: smp_d[0] = rx_s;
        SMP_MID:   smp_d[1] = rx_s;
        SMP_LATE:  smp_d[2] = rx_s;
        default:   smp_d    = smp_q;
      endcase
    end else begin
      edge_cnt_d = {CW{1'b0}};
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // The detect cycle is edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = CW'(1);
          bit_cnt_d  = {BW{1'b0}};
          par_en_d   = Par_en;
          par_type_d = Par_type;
          par_bad_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          if (voted_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = {BW{1'b0}};
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d = {voted_s, shift_q[width-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = {BW{1'b0}};
            if (par_en_q) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          par_bad_d = voted_s ^ parity_of(shift_q) ^ par_type_q;
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_d    = IDLE;
          stop_err_d = ~voted_s;
          par_err_d  = par_bad_q;
          if (voted_s && !par_bad_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end else begin
            p_data_d = p_data_q;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Register FSM state, counters, datapath and all outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      edge_cnt_q   <= {CW{1'b0}};
      bit_cnt_q    <= {BW{1'b0}};
      shift_q      <= {width{1'b0}};
      smp_q        <= 3'b111;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      p_data_q     <= {width{1'b0}};
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      smp_q        <= smp_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (width=8, OVERSAMPLE=8).
// A frame whose start bit is driven just after clock edge c shows up on rx_s
// two edges later (T0), so its strobe is visible after edge c + 2 + 8*N.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       RX_in;
  logic       Par_en;
  logic       Par_type;
  logic [7:0] P_data;
  logic       Data_valid;
  logic       Par_err;
  logic       Stop_err;
  logic       Busy;

  int n_cmp;
  int n_err;
  int cyc;

  // strobe recorder
  int         dv_n, pe_n, se_n;
  int         dv_cyc, dv_prev, pe_cyc, se_cyc;
  logic [7:0] dv_data, dv_data_prev;

  uart_rx #(.width(8), .OVERSAMPLE(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_in      (RX_in),
    .Par_en     (Par_en),
    .Par_type   (Par_type),
    .P_data     (P_data),
    .Data_valid (Data_valid),
    .Par_err    (Par_err),
    .Stop_err   (Stop_err),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter, stepped on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // record strobe counts, the cycle of each strobe and the word presented with it
  always @(negedge clk) begin
    if (Data_valid) begin
      dv_n         <= dv_n + 1;
      dv_prev      <= dv_cyc;
      dv_cyc       <= cyc;
      dv_data_prev <= dv_data;
      dv_data      <= P_data;
    end
    if (Par_err) begin
      pe_n   <= pe_n + 1;
      pe_cyc <= cyc;
    end
    if (Stop_err) begin
      se_n   <= se_n + 1;
      se_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one frame; called #1 after a rising edge, returns #1 after the last bit
  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input logic stop_bit, output int c0);
    logic [10:0] bits;
    int          n;
    bits    = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (has_par) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      n        = 11;
    end else begin
      bits[9] = stop_bit;
      n       = 10;
    end
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      RX_in = bits[i];
      repeat (8) @(posedge clk);
      #1;
    end
    RX_in = 1'b1;
  endtask

  initial begin
    int         c0;
    int         c1;
    logic [7:0] partial;

    n_cmp = 0; n_err = 0; cyc = 0;
    dv_n = 0; pe_n = 0; se_n = 0;
    dv_cyc = 0; dv_prev = 0; pe_cyc = 0; se_cyc = 0;
    dv_data = 8'h00; dv_data_prev = 8'h00;
    rst = 1'b0; RX_in = 1'b1; Par_en = 1'b0; Par_type = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_P_data", P_data, 8'h00);
    check("rst_Data_valid", Data_valid, 1'b0);
    check("rst_Par_err", Par_err, 1'b0);
    check("rst_Stop_err", Stop_err, 1'b0);
    check("rst_Busy", Busy, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // no parity, 0xA5; also watch Busy around T0 and the strobe
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    check("np_dv_count", dv_n, 1);
    check("np_dv_cycle", dv_cyc, c0 + 82);
    check("np_P_data", P_data, 8'hA5);
    check("np_no_par_err", pe_n, 0);
    check("np_no_stop_err", se_n, 0);
    check("np_Busy_idle", Busy, 1'b0);

    // even parity, correct parity bit 0
    Par_en = 1'b1; Par_type = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    check("ev_dv_count", dv_n, 2);
    check("ev_dv_cycle", dv_cyc, c0 + 90);
    check("ev_P_data", P_data, 8'hA5);
    check("ev_no_par_err", pe_n, 0);

    // odd parity, parity bit 0 is wrong; Par_en dropped mid-frame must be ignored
    Par_type = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, c0);
    Par_en = 1'b0; Par_type = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("od_par_err_count", pe_n, 1);
    check("od_par_err_cycle", pe_cyc, c0 + 90);
    check("od_no_dv", dv_n, 2);
    check("od_P_data_held", P_data, 8'hA5);
    check("od_no_stop_err", se_n, 0);

    // 0x3C with the stop bit low
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, c0);
    repeat (4) @(posedge clk);
    #1;
    check("se_count", se_n, 1);
    check("se_cycle", se_cyc, c0 + 82);
    check("se_no_dv", dv_n, 2);
    check("se_P_data_held", P_data, 8'hA5);
    check("se_no_par_err", pe_n, 1);

    // glitch: 3 cycles low, then high
    repeat (4) @(posedge clk);
    #1;
    c0 = cyc;
    RX_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    RX_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("gl_Busy_high", Busy, 1'b1);
    @(posedge clk);
    #1;
    check("gl_Busy_low_at_T0p8", Busy, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("gl_no_dv", dv_n, 2);
    check("gl_no_par_err", pe_n, 1);
    check("gl_no_stop_err", se_n, 1);
    check("gl_P_data_held", P_data, 8'hA5);

    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    check("ag_dv_count", dv_n, 3);
    check("ag_dv_cycle", dv_cyc, c0 + 82);
    check("ag_P_data", P_data, 8'h5A);

    // back-to-back 0x3C then 0xC3
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, c0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, c1);
    repeat (4) @(posedge clk);
    #1;
    check("bb_dv_count", dv_n, 5);
    check("bb_first_cycle", dv_prev, c0 + 82);
    check("bb_second_cycle", dv_cyc, c0 + 162);
    check("bb_first_data", dv_data_prev, 8'h3C);
    check("bb_second_data", P_data, 8'hC3);
    check("bb_no_errs", pe_n + se_n, 2);

    // reset during data bit 4
    partial = 8'h3C;
    RX_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      RX_in = partial[i];
      repeat (8) @(posedge clk);
      #1;
    end
    RX_in = partial[4];
    repeat (4) @(posedge clk);
    #2;
    check("mr_Busy_before", Busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mr_P_data", P_data, 8'h00);
    check("mr_Busy", Busy, 1'b0);
    check("mr_Data_valid", Data_valid, 1'b0);
    check("mr_errs", {Par_err, Stop_err}, 2'b00);
    RX_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    check("mr_no_dv", dv_n, 5);
    check("mr_no_errs", pe_n + se_n, 2);
    check("mr_Busy_idle", Busy, 1'b0);

    send_frame(8'h81, 1'b0, 1'b0, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    check("pr_dv_count", dv_n, 6);
    check("pr_dv_cycle", dv_cyc, c0 + 82);
    check("pr_P_data", P_data, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the serial stage directly downstream of the UART transmitter. It consumes the `TX_out` line and recovers the frame: start bit, `width` data bits LSB first, optional parity bit, one stop bit. On a clean frame it presents the parallel word with a one-cycle `Data_valid` strobe. On a bad frame it pulses a parity or stop error flag instead. Parity configuration matches the transmitter: `Par_en` enables the parity bit, `Par_type` 0 selects even parity and 1 selects odd.

## Interface
- `width`, 8, number of data bits per frame.
- `OVERSAMPLE`, 8, clock cycles per serial bit. Must be an even number ≥ 4.
- `clk`  input  1  single clock. Everything is rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `RX_in`  input  1  serial line. Idles high.
- `Par_en`  input  1  1 = frame carries a parity bit.
- `Par_type`  input  1  0 = even parity, 1 = odd parity.
- `P_data`  output  width  last good received word. Held until the next good frame.
- `Data_valid`  output  1  one-cycle strobe. `P_data` is valid in the same cycle.
- `Par_err`  output  1  one-cycle strobe: parity mismatch.
- `Stop_err`  output  1  one-cycle strobe: stop bit sampled low.
- `Busy`  output  1  high while a frame is being received (any state other than IDLE).

## Operation
- Input synchroniser: two flops on `RX_in`, both reset to 1. Call the synchronised signal `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit counter `edge_cnt` runs 0..OVERSAMPLE-1 within each bit.
- Data counter `bit_cnt` runs 0..width-1 during DATA.
- Sampling: `rx_s` is captured at `edge_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority of those samples. The FSM acts on it at `edge_cnt` = OVERSAMPLE-1.
- IDLE:
  - If `rx_s`=0, go to START with `edge_cnt`=1 (the detect cycle counts as `edge_cnt` 0).
  - Latch `Par_en` and `Par_type` in the detect cycle. Changes to them mid-frame are ignored.
- START, at end of bit:
  - Voted 1 (glitch): return to IDLE. No strobes.
  - Voted 0: go to DATA.
- DATA:
  - Shift the voted bit into an internal shift register, LSB first.
  - After bit `width`-1, go to PARITY if the latched `Par_en` is 1, otherwise go to STOP.
- PARITY:
  - Expected bit = XOR of the received data bits, XOR the latched `Par_type`.
  - Record a mismatch flag, then go to STOP.
- STOP, at end of bit, always return to IDLE:
  - Voted 0: `Stop_err`=1.
  - Mismatch flag set: `Par_err`=1. Both error strobes may assert in the same cycle.
  - No error: `P_data` is loaded from the shift register and `Data_valid`=1.
  - Any error: `P_data` is unchanged and `Data_valid`=0.
- Reset values: `P_data`=0, `Data_valid`=0, `Par_err`=0, `Stop_err`=0, `Busy`=0, state IDLE, counters 0, synchroniser 11.
- Reset asserted mid-frame aborts the frame immediately. No strobes are produced. After release, the FSM waits for a fresh low on `rx_s`.

## Timing
- Latency from `RX_in` to `rx_s` is 2 cycles.
- Let T0 be the cycle in which IDLE sees `rx_s`=0. Let N = 2 + width + `Par_en` (bits per frame).
- Strobes are registered and high for exactly the one cycle T0 + N·OVERSAMPLE:
  - 80 cycles for width=8 without parity.
  - 88 cycles for width=8 with parity.
- In the strobe cycle the state is already IDLE, so a start bit seen in that same cycle is accepted. Back-to-back frames have no dead cycle.
- `Busy` is high from T0+1 through T0 + N·OVERSAMPLE - 1. It is low in the strobe cycle.
- Glitch rejection: a low pulse shorter than OVERSAMPLE/2 cycles (as seen on `rx_s`) returns the FSM to IDLE at T0 + OVERSAMPLE. No outputs change.
- Jitter tolerance: the majority vote tolerates edge misalignment of up to ±(OVERSAMPLE/2-2) cycles per bit.

## Test plan
All scenarios use width=8, OVERSAMPLE=8, with each bit held on `RX_in` for 8 cycles.
- No parity, send 0xA5 -> `Data_valid`=1 for one cycle at T0+80, `P_data`=0xA5, both error flags 0.
- `Par_en`=1, `Par_type`=0, send 0xA5 with parity bit 0 -> `Data_valid` at T0+88, `P_data`=0xA5. Repeat with `Par_type`=1 and parity bit 0 -> `Par_err` pulse at T0+88, no `Data_valid`, `P_data` still 0xA5.
- Send 0x3C with the stop bit driven 0 -> `Stop_err` pulse at T0+80, `Data_valid`=0, `P_data` unchanged.
- Drive `RX_in` low for 3 cycles, then high -> no strobes, `Busy` falls at T0+8. A following valid 0x5A frame is received correctly.
- Back-to-back: send 0x3C then 0xC3 with no idle gap -> two `Data_valid` strobes exactly 80 cycles apart, `P_data` 0x3C then 0xC3.
- Assert `rst` during data bit 4 of a frame -> all outputs 0 immediately. After release with `RX_in` high, there are no strobes, and the next 0x81 frame is received correctly.
